program_loader: RTL and testbench



---
 rtl/constant.sv | 22 ++
 rtl/program_loader.sv | 143 ++++++++++++++
 tb/tb_program_loader.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/constant.sv
// Shared constants for the CPU front end.
//   HANDSHAKE_BYTE : byte the execute stage sends to the host before a load
//   MODE_*         : core controller mode encodings
//   loader_state_t : program_loader FSM states
package constant;

  localparam logic [7:0] HANDSHAKE_BYTE = 8'hAA;

  localparam logic [1:0] MODE_IDLE = 2'd0;
  localparam logic [1:0] MODE_LOAD = 2'd1;
  localparam logic [1:0] MODE_EXEC = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COUNT,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } loader_state_t;

endpackage

// File: rtl/program_loader.sv
// program_loader: receives a program image from the UART byte stream after the
// host handshake and writes it word-by-word into instruction memory.
// Image: 4-byte big-endian word count N, N big-endian 32-bit words, then one
// checksum byte equal to the XOR of all data-word bytes.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   aa_sent           handshake byte has left the TX queue (starts the load)
//   rx_data/valid/ferr received byte, strobe, framing error
//   imem_we/addr/wdata one-cycle instruction-memory write
//   load_done/err     terminal status levels
//   load_count        words written so far
//
// state    | meaning
// ---------+----------------------------------------------------
// ST_IDLE  | waiting for aa_sent, all bytes ignored
// ST_COUNT | shifting in the 4-byte word count
// ST_DATA  | assembling words, writing each completed word
// ST_CSUM  | waiting for the checksum byte
// ST_DONE  | image loaded, checksum correct (terminal)
// ST_ERR   | oversize count, framing error or bad checksum (terminal)
module program_loader
  import constant::*;
#(
  parameter int IMEM_ADDR_W = 14
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   aa_sent,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  input  logic                   rx_ferr,
  output logic                   imem_we,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  output logic [31:0]            imem_wdata,
  output logic                   load_done,
  output logic                   load_err,
  output logic [IMEM_ADDR_W:0]   load_count
);

  // Compared on 33 bits so any 32-bit count above capacity is caught.
  localparam logic [32:0] CAPACITY = 33'd1 << IMEM_ADDR_W;

  loader_state_t          state;
  logic [1:0]             byte_idx;
  logic [31:0]            asm_q;
  logic [7:0]             csum_acc;
  logic [IMEM_ADDR_W:0]   n_words;

  logic [31:0]            asm_next;
  logic [IMEM_ADDR_W:0]   count_next;
  logic                   last_byte;

  assign asm_next   = {asm_q[23:0], rx_data};
  assign count_next = load_count + (IMEM_ADDR_W + 1)'(1);
  assign last_byte  = (byte_idx == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      byte_idx   <= 2'd0;
      asm_q      <= 32'd0;
      csum_acc   <= 8'd0;
      n_words    <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'd0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
      load_count <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (aa_sent) begin
            state    <= ST_COUNT;
            byte_idx <= 2'd0;
            csum_acc <= 8'd0;
          end
        end

        ST_COUNT: begin
          if (rx_valid) begin
            if (rx_ferr) begin
              state    <= ST_ERR;
              load_err <= 1'b1;
            end else begin
              asm_q    <= asm_next;
              byte_idx <= byte_idx + 2'd1;
              if (last_byte) begin
                n_words <= asm_next[IMEM_ADDR_W:0];
                if ({1'b0, asm_next} > CAPACITY) begin
                  state    <= ST_ERR;
                  load_err <= 1'b1;
                end else if (asm_next == 32'd0) begin
                  state <= ST_CSUM;
                end else begin
                  state <= ST_DATA;
                end
              end
            end
          end
        end

        ST_DATA: begin
          if (rx_valid) begin
            if (rx_ferr) begin
              // partial word is dropped, nothing written
              state    <= ST_ERR;
              load_err <= 1'b1;
            end else begin
              asm_q    <= asm_next;
              csum_acc <= csum_acc ^ rx_data;
              byte_idx <= byte_idx + 2'd1;
              if (last_byte) begin
                imem_we    <= 1'b1;
                imem_addr  <= load_count[IMEM_ADDR_W-1:0];
                imem_wdata <= asm_next;
                load_count <= count_next;
                if (count_next == n_words) state <= ST_CSUM;
              end
            end
          end
        end

        ST_CSUM: begin
          if (rx_valid) begin
            if (!rx_ferr && rx_data == csum_acc) begin
              state     <= ST_DONE;
              load_done <= 1'b1;
            end else begin
              state    <= ST_ERR;
              load_err <= 1'b1;
            end
          end
        end

        default: ;  // ST_DONE / ST_ERR hold until reset
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

  localparam int AW  = 4;
  localparam longint CAP = 64'd1 << AW;

  typedef logic [8:0] rxb_t;      // {ferr, data}
  typedef rxb_t rxq_t[$];

  logic          clk = 1'b0;
  logic          rst;
  logic          aa_sent;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ferr;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          load_done;
  logic          load_err;
  logic [AW:0]   load_count;

  int n_checks = 0;
  int n_pass   = 0;

  logic [63:0] obs_q[$];
  logic [63:0] exp_q[$];
  bit          exp_done;
  bit          exp_err;

  program_loader #(.IMEM_ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .aa_sent    (aa_sent),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ferr    (rx_ferr),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .load_done  (load_done),
    .load_err   (load_err),
    .load_count (load_count)
  );

  always #5 clk = ~clk;

  // imem_we is high from one posedge to the next, so each pulse is seen once here
  always @(negedge clk)
    if (imem_we) obs_q.push_back({32'(imem_addr), imem_wdata});

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: walks the byte stream by position within the image.
  task automatic model_run(input rxq_t s);
    longint n;
    logic [31:0] w;
    logic [7:0]  x;
    exp_q.delete();
    exp_done = 0;
    exp_err  = 0;
    n = 0; w = 0; x = 0;
    for (int p = 0; p < s.size(); p++) begin
      if (exp_done || exp_err) break;
      if (s[p][8]) begin exp_err = 1; break; end
      if (p < 4) begin
        n = (n << 8) | longint'(s[p][7:0]);
        if (p == 3 && n > CAP) exp_err = 1;
      end else if (longint'(p) < 4 + 4 * n) begin
        w = {w[23:0], s[p][7:0]};
        x = x ^ s[p][7:0];
        if ((p - 4) % 4 == 3) exp_q.push_back({32'((p - 4) / 4), w});
      end else begin
        if (s[p][7:0] == x) exp_done = 1;
        else exp_err = 1;
      end
    end
  endtask

  function automatic rxq_t build_image(input int n, input logic [31:0] words[$], input bit bad_csum);
    rxq_t s;
    logic [7:0] x = 8'h00;
    logic [31:0] nn = 32'(n);
    for (int i = 3; i >= 0; i--) s.push_back({1'b0, nn[i*8 +: 8]});
    foreach (words[i])
      for (int b = 3; b >= 0; b--) begin
        s.push_back({1'b0, words[i][b*8 +: 8]});
        x = x ^ words[i][b*8 +: 8];
      end
    s.push_back({1'b0, bad_csum ? ~x : x});
    return s;
  endfunction

  task automatic drive_stream(input rxq_t s, input bit rand_gap);
    foreach (s[i]) begin
      rx_data  = s[i][7:0];
      rx_ferr  = s[i][8];
      rx_valid = 1'b1;
      @(posedge clk); #1;
      rx_valid = 1'b0;
      rx_ferr  = 1'b0;
      if (rand_gap) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; aa_sent = 1'b0; rx_valid = 1'b0; rx_ferr = 1'b0; rx_data = 8'h00;
    @(posedge clk); #1;
    rst = 1'b0;
    obs_q.delete();
  endtask

  task automatic start_load();
    aa_sent = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic compare_run(input string tag);
    repeat (3) @(posedge clk);
    #1;
    check({tag, ".nwr"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s.wr%0d", tag, i), obs_q[i], exp_q[i]);
    check({tag, ".count"}, 64'(load_count), 64'(exp_q.size()));
    check({tag, ".done"},  64'(load_done),  64'(exp_done));
    check({tag, ".err"},   64'(load_err),   64'(exp_err));
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".we"},    64'(imem_we),    64'd0);
    check({tag, ".addr"},  64'(imem_addr),  64'd0);
    check({tag, ".wdata"}, 64'(imem_wdata), 64'd0);
    check({tag, ".done"},  64'(load_done),  64'd0);
    check({tag, ".err"},   64'(load_err),   64'd0);
    check({tag, ".count"}, 64'(load_count), 64'd0);
  endtask

  initial begin
    rxq_t s, pre;
    logic [31:0] words[$];
    int n, mode, pos;

    do_reset();
    check_zero("reset");

    // Normal load; XOR of the eight data bytes is 0x89.
    words = '{32'h20010005, 32'hAC010000};
    s = build_image(2, words, 0);
    model_run(s);
    start_load();
    pre = s[0:7];
    drive_stream(pre, 0);
    check("t1.we_k1",   64'(imem_we),    64'd1);
    check("t1.wdata_k1", 64'(imem_wdata), 64'h20010005);
    @(posedge clk); #1;
    check("t1.we_once", 64'(imem_we),    64'd0);
    pre = s[8:12];
    drive_stream(pre, 0);
    check("t1.done_k1", 64'(load_done),  64'd1);
    check("t1.cnt_k1",  64'(load_count), 64'd2);
    compare_run("t1");

    // Bad checksum, then a trailing byte must not cause a write.
    do_reset();
    s = build_image(2, words, 0);
    s[12] = {1'b0, 8'h8D};
    s.push_back({1'b0, 8'h55});
    model_run(s);
    start_load();
    drive_stream(s, 1);
    compare_run("t2");

    // Oversize count.
    do_reset();
    words.delete();
    s = build_image(17, words, 0);
    model_run(s);
    start_load();
    drive_stream(s, 0);
    compare_run("t3a");

    // Exactly full memory.
    do_reset();
    words.delete();
    for (int i = 0; i < 16; i++) words.push_back($urandom);
    s = build_image(16, words, 0);
    model_run(s);
    start_load();
    drive_stream(s, 1);
    compare_run("t3b");

    // Bytes before aa_sent and in its first cycle are ignored; then N=0.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      rx_data = 8'(($urandom & 8'h7F) | 8'h80); rx_valid = 1'b1;
      @(posedge clk); #1;
      rx_valid = 1'b0;
    end
    aa_sent = 1'b1; rx_data = 8'hFF; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    words.delete();
    s = build_image(0, words, 0);
    model_run(s);
    drive_stream(s, 0);
    compare_run("t4");

    // Framing error on the 3rd byte of word 1.
    do_reset();
    words = '{32'h11223344, 32'h55667788, 32'h99AABBCC};
    s = build_image(3, words, 0);
    s[10][8] = 1'b1;
    model_run(s);
    start_load();
    drive_stream(s, 1);
    compare_run("t5");

    // Reset mid-word with a strobe in the same cycle, then a clean reload.
    do_reset();
    words = '{32'hDEADBEEF, 32'h01234567};
    s = build_image(2, words, 0);
    start_load();
    pre = s[0:9];
    drive_stream(pre, 0);
    rst = 1'b1; rx_valid = 1'b1; rx_data = 8'h45;
    @(posedge clk); #1;
    rst = 1'b0; rx_valid = 1'b0;
    check_zero("t6.rst");
    obs_q.delete();
    @(posedge clk); #1;
    model_run(s);
    drive_stream(s, 1);
    compare_run("t6.reload");

    // Random images with random faults and spacing.
    for (int it = 0; it < 25; it++) begin
      do_reset();
      n = $urandom_range(0, 17);
      mode = $urandom_range(0, 2);
      words.delete();
      for (int i = 0; i < n; i++) words.push_back($urandom);
      s = build_image(n, words, mode == 1);
      if (mode == 2) begin
        pos = $urandom_range(0, s.size() - 1);
        s[pos][8] = 1'b1;
      end
      model_run(s);
      start_load();
      drive_stream(s, 1);
      compare_run($sformatf("rnd%0d", it));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
